ps2_kbd_rx: RTL



---
 rtl/ps2_kbd_rx_pkg.sv | 15 +
 rtl/ps2_kbd_rx_if.sv | 9 +
 rtl/ps2_kbd_rx_sync_filter.sv | 35 +++
 rtl/ps2_kbd_rx.sv | 127 ++++++++++++
 4 files changed

// File: rtl/ps2_kbd_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] BREAK_CODE      = 8'hF0;
    localparam logic [7:0] EXT_CODE        = 8'hE0;
    localparam int         FRAME_DATA_BITS = 8;

    // Odd parity holds when data and parity bit together carry an odd number of ones.
    function automatic logic odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Scan-code delivery bundle from the keyboard receiver to the cpu.
interface ps2_kbd_rx_if;
    logic [7:0] kd;
    logic       kv;
    logic       kerr;

    modport master (output kd, kv, kerr);
    modport slave  (input  kd, kv, kerr);
endinterface

// File: rtl/ps2_kbd_rx_sync_filter.sv
// Two-flop synchronizer followed by a stability filter; output idles high.
module ps2_sync_filter #(
    parameter int FILTER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILTER + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive synced samples disagree with dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            dout <= 1'b1;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER - 1)) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: framing, odd parity, timeout and optional break stripping.
import ps2_pkg::*;

module ps2_kbd_rx #(
    parameter int FILTER     = 4,
    parameter int TIMEOUT    = 2000,
    parameter bit DROP_BREAK = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master kbd
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(FRAME_DATA_BITS);

    logic          fclk, fdata, fclk_q, fall;
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d, kd_q, kd_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          par_q, par_d, brk_q, brk_d;
    logic          kv_q, kv_d, kerr_q, kerr_d;

    ps2_sync_filter #(.FILTER(FILTER)) u_clk_filt (
        .clk(clk), .rst(rst), .din(ps2_clk), .dout(fclk)
    );
    ps2_sync_filter #(.FILTER(FILTER)) u_data_filt (
        .clk(clk), .rst(rst), .din(ps2_data), .dout(fdata)
    );

    assign fall = fclk_q & ~fclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            fclk_q  <= 1'b1;
            state_q <= IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            par_q   <= 1'b0;
            brk_q   <= 1'b0;
            kd_q    <= '0;
            kv_q    <= 1'b0;
            kerr_q  <= 1'b0;
        end else begin
            fclk_q  <= fclk;
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            par_q   <= par_d;
            brk_q   <= brk_d;
            kd_q    <= kd_d;
            kv_q    <= kv_d;
            kerr_q  <= kerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        brk_d   = brk_q;
        kd_d    = kd_q;
        kv_d    = 1'b0;
        kerr_d  = 1'b0;
        tcnt_d  = tcnt_q;

        // Saturating idle-time counter, only meaningful mid-frame.
        if (fall || state_q == IDLE)
            tcnt_d = '0;
        else if (tcnt_q != TW'(TIMEOUT))
            tcnt_d = tcnt_q + 1'b1;

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!fdata) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end else begin
                        kerr_d = 1'b1;
                        brk_d  = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = {fdata, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(FRAME_DATA_BITS - 1))
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = fdata;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (fdata && odd_ok(shift_q, par_q)) begin
                        if (DROP_BREAK && shift_q == BREAK_CODE) begin
                            brk_d = 1'b1;
                        end else if (DROP_BREAK && brk_q) begin
                            brk_d = 1'b0;
                        end else begin
                            kd_d = shift_q;
                            kv_d = 1'b1;
                        end
                    end else begin
                        kerr_d = 1'b1;
                        brk_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT)) begin
            state_d = IDLE;
            kerr_d  = 1'b1;
            brk_d   = 1'b0;
        end
    end

    assign kbd.kd   = kd_q;
    assign kbd.kv   = kv_q;
    assign kbd.kerr = kerr_q;
endmodule
